// File: rtl/regfile_multiport.sv
// Multi-read, single-write register file with r0 hardwired to zero and a post-reset clearing sweep.
// Optional write-through forwarding to the read ports when RF_BYPASS_EN is defined.
module regfile_multiport #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     ready,
  output logic                     wr_drop
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q;
  logic [ADDR_W:0]   cnt_q;
  logic              ready_q;
  logic              drop_q;

  logic [DATA_W-1:0] mem_q [1:DEPTH-1];

  logic              run_wr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign run_wr = (state_q == RUN) && wr_en && (wr_addr != '0);

  // The sweep and the architectural write share one RAM port.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wr_addr;
    mem_wd = wr_data;
    if (state_q == INIT) begin
      mem_we = 1'b1;
      mem_wa = cnt_q[ADDR_W-1:0];
      mem_wd = '0;
    end else if (run_wr) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= (ADDR_W+1)'(1);
      ready_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          cnt_q  <= cnt_q + (ADDR_W+1)'(1);
          drop_q <= wr_en;
          if (cnt_q == LAST) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          drop_q <= 1'b0;
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

  assign ready   = ready_q;
  assign wr_drop = drop_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    always_comb begin
      rd_data[k*DATA_W +: DATA_W] = '0;
      if (state_q == RUN && a != '0) begin
`ifdef RF_BYPASS_EN
        if (run_wr && wr_addr == a)
          rd_data[k*DATA_W +: DATA_W] = wr_data;
        else
          rd_data[k*DATA_W +: DATA_W] = mem_q[a];
`else
        rd_data[k*DATA_W +: DATA_W] = mem_q[a];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: driver pushes expectations from a
// behavioural model, a negedge monitor pops and compares them.
module tb_regfile_multiport;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            ready;
  logic            wr_drop;

  regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(ready), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model: register contents plus elapsed cycles since reset release.
  logic [DW-1:0] m_mem [32];
  int  m_cyc;
  bit  m_drop;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic bit m_ready();
    return (m_cyc >= 31) && (rst_n == 1'b1);
  endfunction

  function automatic logic [63:0] m_read(logic [AW-1:0] a);
    if (!m_ready() || a == 0) return '0;
    if (BYP && wr_en && wr_addr != 0 && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_cyc  = 0;
    m_drop = 1'b0;
  endtask

  task automatic cyc(bit we, logic [AW-1:0] wa, logic [DW-1:0] wd,
                     logic [AW-1:0] a0, logic [AW-1:0] a1);
    exp_t e;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = {a1, a0};
    e.kind = 0; e.exp = m_read(a0);          q.push_back(e);
    e.kind = 1; e.exp = m_read(a1);          q.push_back(e);
    e.kind = 2; e.exp = 64'(m_ready());      q.push_back(e);
    e.kind = 3; e.exp = 64'(m_drop);         q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      bit rdy;
      rdy = m_ready();
      m_drop = we && !rdy;
      if (rdy && we && wa != 0) m_mem[wa] = wd;
      if (m_cyc < 1000) m_cyc++;
    end
    #1;
  endtask

  task automatic reset_for(int n);
    rst_n = 1'b0;
    m_reset();
    repeat (n) cyc(1'b0, '0, '0, 5'd0, 5'd1);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready();
    while (!m_ready()) cyc(1'b0, '0, '0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endtask

  initial begin : monitor
    exp_t e;
    logic [63:0] act;
    string nm;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        unique case (e.kind)
          0: begin act = rd_data[0 +: DW];  nm = "rd0";     end
          1: begin act = rd_data[DW +: DW]; nm = "rd1";     end
          2: begin act = 64'(ready);        nm = "ready";   end
          default: begin act = 64'(wr_drop); nm = "wr_drop"; end
        endcase
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, e.exp);
        end
      end
    end
  end

  initial begin : driver
    m_reset();
    #1;
    reset_for(3);
    // Sweep window, with a rejected write two cycles after release.
    cyc(1'b0, '0, '0, 5'd3, 5'd7);
    cyc(1'b0, '0, '0, 5'd7, 5'd0);
    cyc(1'b1, 5'd7, 64'hAAAA_5555_AAAA_5555, 5'd7, 5'd7);
    cyc(1'b0, '0, '0, 5'd7, 5'd2);
    cyc(1'b0, '0, '0, 5'd7, 5'd2);
    wait_ready();
    cyc(1'b0, '0, '0, 5'd7, 5'd31);
    cyc(1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 5'd1, 5'd2);
    cyc(1'b0, '0, '0, 5'd5, 5'd5);
    cyc(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd5);
    cyc(1'b0, '0, '0, 5'd0, 5'd0);
    cyc(1'b1, 5'd9, 64'h1234, 5'd9, 5'd0);
    cyc(1'b0, '0, '0, 5'd9, 5'd9);
    for (int r = 1; r < 32; r++) cyc(1'b1, 5'(r), 64'(r), 5'(r), 5'(r - 1));
    cyc(1'b0, '0, '0, 5'd31, 5'd17);
    reset_for(1);
    wait_ready();
    for (int r = 0; r < 32; r++) cyc(1'b0, '0, '0, 5'(r), 5'(31 - r));
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset_for(2);
        for (int j = 0; j < 8; j++)
          cyc(1'($urandom), 5'($urandom), {$urandom, $urandom}, 5'($urandom), 5'($urandom));
        wait_ready();
      end
      cyc(1'($urandom), 5'($urandom_range(0, 31)), {$urandom, $urandom},
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    cyc(1'b0, '0, '0, 5'd0, 5'd0);
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
